// File: rtl/depth_test_writer.sv
// Per-pixel depth test and framebuffer/depth writer, one pixel in flight.
// Optional DEPTH_TEST_STATS_EN adds written/rejected/clipped counters.
module depth_test_writer #(
    parameter  int WIDTH      = 320,
    parameter  int HEIGHT     = 240,
    parameter  int DEPTH_BITS = 26,
    localparam int ADDR_BITS  = $clog2(WIDTH * HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           in_pixel_x,
    input  logic [15:0]           in_pixel_y,
    input  logic [DEPTH_BITS-1:0] in_depth,
    input  logic [15:0]           in_color,
    input  logic                  in_compare_depth,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  depth_rd_en,
    output logic [ADDR_BITS-1:0]  depth_rd_addr,
    input  logic [DEPTH_BITS-1:0] depth_rd_data,
    output logic                  depth_wr_en,
    output logic [ADDR_BITS-1:0]  depth_wr_addr,
    output logic [DEPTH_BITS-1:0] depth_wr_data,
    output logic [ADDR_BITS-1:0]  fb_wr_addr,
    output logic [15:0]           fb_wr_color,
    output logic                  fb_wr_valid,
    input  logic                  fb_wr_ready,
`ifdef DEPTH_TEST_STATS_EN
    input  logic                  stat_clear,
    output logic [31:0]           stat_written,
    output logic [31:0]           stat_rejected,
    output logic [31:0]           stat_clipped,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, COMPARE, WRITE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DEPTH_BITS-1:0] r_depth;
    logic [15:0]           r_color;

    logic                  w_accept;
    logic                  w_clip;
    logic                  w_pass;
    logic                  w_fb_hs;
    logic [ADDR_BITS-1:0]  w_addr;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_clip   = (in_pixel_x >= 16'(WIDTH)) || (in_pixel_y >= 16'(HEIGHT));
    assign w_pass   = r_depth < depth_rd_data;
    assign w_fb_hs  = (r_state == WRITE) && fb_wr_ready;
    assign w_addr   = ADDR_BITS'(in_pixel_y) * ADDR_BITS'(WIDTH)
                    + ADDR_BITS'(in_pixel_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_depth <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_clip) begin
                r_addr  <= w_addr;
                r_depth <= in_depth;
                r_color <= in_color;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid && !w_clip)
                    w_next = in_compare_depth ? READ : WRITE;
            end
            READ:    w_next = COMPARE;
            COMPARE: w_next = w_pass ? WRITE : IDLE;
            WRITE:   w_next = fb_wr_ready ? IDLE : WRITE;
            default: w_next = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so every output reads 0 while in reset
    always_comb begin
        in_ready      = rst_n && (r_state == IDLE);
        busy          = r_state != IDLE;
        depth_rd_en   = r_state == READ;
        depth_rd_addr = (r_state == READ) ? r_addr : '0;
        fb_wr_valid   = r_state == WRITE;
        fb_wr_addr    = (r_state == WRITE) ? r_addr : '0;
        fb_wr_color   = (r_state == WRITE) ? r_color : '0;
        depth_wr_en   = w_fb_hs;
        depth_wr_addr = w_fb_hs ? r_addr : '0;
        depth_wr_data = w_fb_hs ? r_depth : '0;
    end

`ifdef DEPTH_TEST_STATS_EN
    logic [31:0] r_stat_written;
    logic [31:0] r_stat_rejected;
    logic [31:0] r_stat_clipped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_written  <= '0;
            r_stat_rejected <= '0;
            r_stat_clipped  <= '0;
        end else if (stat_clear) begin
            r_stat_written  <= '0;
            r_stat_rejected <= '0;
            r_stat_clipped  <= '0;
        end else begin
            if (w_fb_hs)
                r_stat_written <= r_stat_written + 32'd1;
            if (r_state == COMPARE && !w_pass)
                r_stat_rejected <= r_stat_rejected + 32'd1;
            if (w_accept && w_clip)
                r_stat_clipped <= r_stat_clipped + 32'd1;
        end
    end

    assign stat_written  = r_stat_written;
    assign stat_rejected = r_stat_rejected;
    assign stat_clipped  = r_stat_clipped;
`endif

endmodule

// File: tb/tb_depth_test_writer.sv
// Directed bench for depth_test_writer with a behavioural sync depth RAM.
// Covers fill, pass, reject/equal, clip, backpressure and mid-write reset.
module tb_depth_test_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_pixel_x = '0;
    logic [15:0] in_pixel_y = '0;
    logic [25:0] in_depth = '0;
    logic [15:0] in_color = '0;
    logic        in_compare_depth = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        depth_rd_en;
    logic [16:0] depth_rd_addr;
    logic [25:0] depth_rd_data = '0;
    logic        depth_wr_en;
    logic [16:0] depth_wr_addr;
    logic [25:0] depth_wr_data;
    logic [16:0] fb_wr_addr;
    logic [15:0] fb_wr_color;
    logic        fb_wr_valid;
    logic        fb_wr_ready = 1'b1;
    logic        busy;
`ifdef DEPTH_TEST_STATS_EN
    logic        stat_clear = 1'b0;
    logic [31:0] stat_written;
    logic [31:0] stat_rejected;
    logic [31:0] stat_clipped;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int n_fb   = 0;
    int n_dw   = 0;
    int n_rd   = 0;
    int base_fb, base_dw, base_rd;

    logic [25:0] ram [0:76799];

    always #5 clk = ~clk;

    depth_test_writer dut (
        .clk(clk), .rst_n(rst_n),
        .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y),
        .in_depth(in_depth), .in_color(in_color),
        .in_compare_depth(in_compare_depth),
        .in_valid(in_valid), .in_ready(in_ready),
        .depth_rd_en(depth_rd_en), .depth_rd_addr(depth_rd_addr),
        .depth_rd_data(depth_rd_data),
        .depth_wr_en(depth_wr_en), .depth_wr_addr(depth_wr_addr),
        .depth_wr_data(depth_wr_data),
        .fb_wr_addr(fb_wr_addr), .fb_wr_color(fb_wr_color),
        .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
`ifdef DEPTH_TEST_STATS_EN
        .stat_clear(stat_clear), .stat_written(stat_written),
        .stat_rejected(stat_rejected), .stat_clipped(stat_clipped),
`endif
        .busy(busy)
    );

    always @(posedge clk) begin
        if (depth_rd_en) depth_rd_data <= ram[depth_rd_addr];
        if (depth_wr_en) ram[depth_wr_addr] <= depth_wr_data;
        if (depth_rd_en) n_rd <= n_rd + 1;
        if (depth_wr_en) n_dw <= n_dw + 1;
        if (fb_wr_valid && fb_wr_ready) n_fb <= n_fb + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one pixel for one cycle; returns on the negedge after accept
    task automatic send(input int x, input int y, input logic [25:0] d,
                        input logic [15:0] c, input logic cmp);
        in_pixel_x       = 16'(x);
        in_pixel_y       = 16'(y);
        in_depth         = d;
        in_color         = c;
        in_compare_depth = cmp;
        in_valid         = 1'b1;
        @(negedge clk);
        in_valid         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 76800; i++) ram[i] = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", {62'd0, in_ready, busy}, 64'h2);
        check("reset_outs", {fb_wr_valid, depth_rd_en, depth_wr_en,
              fb_wr_addr, fb_wr_color}, 64'd0);

        // 1: fill
        base_rd = n_rd;
        send(5, 2, '1, 16'h1234, 1'b0);
        check("fill_fb", {fb_wr_valid, fb_wr_addr, fb_wr_color},
              {1'b1, 17'd645, 16'h1234});
        check("fill_dw", {depth_wr_en, depth_wr_addr, depth_wr_data},
              {1'b1, 17'd645, 26'h3FFFFFF});
        check("fill_busy", {in_ready, busy}, 2'b01);
        @(negedge clk);
        check("fill_idle", {in_ready, busy}, 2'b10);
        check("fill_no_rd", n_rd, base_rd);

        // 2: compared pass
        ram[645] = 26'd1000;
        base_fb  = n_fb;
        send(5, 2, 26'd500, 16'h0F0F, 1'b1);
        check("pass_rd", {depth_rd_en, depth_rd_addr}, {1'b1, 17'd645});
        @(negedge clk);
        check("pass_cmp", {depth_rd_en, fb_wr_valid, in_ready}, 3'b000);
        @(negedge clk);
        check("pass_fb", {fb_wr_valid, fb_wr_addr, fb_wr_color},
              {1'b1, 17'd645, 16'h0F0F});
        check("pass_dw", {depth_wr_en, depth_wr_data}, {1'b1, 26'd500});
        @(negedge clk);
        check("pass_idle", {in_ready, busy}, 2'b10);
        check("pass_ram", ram[645], 26'd500);
        check("pass_fbcnt", n_fb, base_fb + 1);

        // 3: equal then greater depth, both rejected
        base_fb = n_fb;
        base_dw = n_dw;
        send(5, 2, 26'd500, 16'hAAAA, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("eq_idle", {in_ready, busy}, 2'b10);
        send(5, 2, 26'd700, 16'hBBBB, 1'b1);
        @(negedge clk);
        check("gt_cmp", {busy, fb_wr_valid}, 2'b10);
        @(negedge clk);
        check("gt_idle", {in_ready, busy}, 2'b10);
        check("rej_nofb", n_fb, base_fb);
        check("rej_nodw", n_dw, base_dw);
        check("rej_ram", ram[645], 26'd500);

        // 4: clipping
        base_rd = n_rd;
        base_dw = n_dw;
        base_fb = n_fb;
        send(320, 0, 26'd1, 16'h1111, 1'b1);
        check("clip_x", {in_ready, busy}, 2'b10);
        send(0, 240, 26'd1, 16'h2222, 1'b0);
        check("clip_y", {in_ready, busy}, 2'b10);
        check("clip_nomem", {n_rd, n_dw, n_fb}, {base_rd, base_dw, base_fb});
`ifdef DEPTH_TEST_STATS_EN
        check("stat_clipped", stat_clipped, 32'd2);
        check("stat_rejected", stat_rejected, 32'd2);
        check("stat_written", stat_written, 32'd2);
`endif

        // 5: backpressure, addr 3*320+7 = 967
        fb_wr_ready = 1'b0;
        base_dw = n_dw;
        send(7, 3, 26'd42, 16'hBEEF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {fb_wr_valid, in_ready, depth_wr_en,
                  fb_wr_addr, fb_wr_color},
                  {1'b1, 1'b0, 1'b0, 17'd967, 16'hBEEF});
            @(negedge clk);
        end
        fb_wr_ready = 1'b1;
        #1;
        check("bp_dw", {depth_wr_en, depth_wr_addr, depth_wr_data},
              {1'b1, 17'd967, 26'd42});
        @(negedge clk);
        check("bp_one_pulse", n_dw, base_dw + 1);
        check("bp_idle", {in_ready, fb_wr_valid}, 2'b10);

        // 6: reset during WRITE, addr 10*320+10 = 3210
        fb_wr_ready = 1'b0;
        base_fb = n_fb;
        base_dw = n_dw;
        send(10, 10, 26'd9, 16'hCAFE, 1'b0);
        check("rst_inwrite", fb_wr_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {in_ready, busy, fb_wr_valid, depth_rd_en,
              depth_wr_en, fb_wr_addr, fb_wr_color}, 64'd0);
        fb_wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", {in_ready, busy, fb_wr_valid}, 3'b100);
        check("rst_no_write", {n_fb, n_dw}, {base_fb, base_dw});
        check("rst_ram", ram[3210], 26'h3FFFFFF);
`ifdef DEPTH_TEST_STATS_EN
        check("stat_reset", {stat_written, stat_clipped}, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/depth_test_writer.md
Name: depth_test_writer

Overview:
- Sink for the renderer's pixel stream: x, y, depth, color, compare_depth, with valid/ready.
- Performs the per-pixel depth test against an external synchronous depth RAM.
- Pixels that pass, and all non-compared fill pixels, are issued to the framebuffer write port with a valid/ready handshake; the depth RAM is updated on the same cycle.
- Sits between the render manager output and the framebuffer/depth memories.

Parameters:
- WIDTH, 320, screen width in pixels.
- HEIGHT, 240, screen height in pixels.
- DEPTH_BITS, 26, depth word width (16 + clog2(FAR-NEAR) at defaults).
- localparam ADDR_BITS, $clog2(WIDTH*HEIGHT), linear pixel address width (17 at defaults).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_pixel_x  in  16  pixel column
in_pixel_y  in  16  pixel row
in_depth  in  DEPTH_BITS  pixel depth, smaller = nearer
in_color  in  16  color16 pixel value
in_compare_depth  in  1  1 = depth-test, 0 = unconditional write (screen fill)
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
depth_rd_en  out  1  depth RAM read strobe
depth_rd_addr  out  ADDR_BITS  depth RAM read address
depth_rd_data  in  DEPTH_BITS  read data, valid exactly 1 cycle after depth_rd_en
depth_wr_en  out  1  depth RAM write strobe
depth_wr_addr  out  ADDR_BITS  depth RAM write address
depth_wr_data  out  DEPTH_BITS  depth RAM write data
fb_wr_addr  out  ADDR_BITS  framebuffer address
fb_wr_color  out  16  framebuffer color
fb_wr_valid  out  1  framebuffer write request
fb_wr_ready  in  1  framebuffer accepts when fb_wr_valid && fb_wr_ready
busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset:
  - State goes to IDLE; all registers clear.
  - in_ready=1 after reset release; every other output is 0.
  - Reset asserted mid-operation aborts the pending pixel: no fb or depth write is issued for it.
- States: IDLE, READ, COMPARE, WRITE.
- IDLE:
  - in_ready=1.
  - On accept, register x, y, depth, color, compare flag, and addr = y*WIDTH + x (ADDR_BITS, unsigned).
  - If x >= WIDTH or y >= HEIGHT: pixel is dropped (clipped); stay IDLE; no memory access.
  - Else if compare=0: go to WRITE.
  - Else: go to READ.
- READ:
  - depth_rd_en=1 and depth_rd_addr=addr for exactly 1 cycle.
  - Go to COMPARE.
- COMPARE:
  - Sample depth_rd_data.
  - If in_depth < stored (strict, unsigned): go to WRITE.
  - Else: pixel rejected; go to IDLE. Equal depth is rejected.
- WRITE:
  - fb_wr_valid=1, fb_wr_addr=addr, fb_wr_color=color.
  - Outputs stay stable until fb_wr_ready.
  - On the handshake cycle, depth_wr_en=1 for that cycle only, with depth_wr_addr=addr and depth_wr_data=depth; then go to IDLE.
- Ready/stall:
  - in_ready=0 in READ, COMPARE and WRITE.
  - Upstream must hold the pixel stable while stalled.
  - No new pixel is accepted in the cycle WRITE completes; it is accepted at the earliest in the next (IDLE) cycle.
- Throughput: one pixel in flight at a time.
  - Fill pixel: 2 cycles minimum.
  - Compared pass: 4 cycles minimum.
  - Compared reject: 3 cycles.
  - Clipped: 1 cycle.
- Ordering: the depth write lands before any later read, so same-pixel read-after-write is always coherent without forwarding.
- Address multiply uses a constant WIDTH; result is truncated to ADDR_BITS, with no overflow for in-range x and y.

Optional Feature:
- Macro: DEPTH_TEST_STATS_EN.
- When defined, adds three outputs, each 32 bits:
  - stat_written: increments on each fb handshake.
  - stat_rejected: increments on each depth-fail.
  - stat_clipped: increments on each out-of-bounds drop.
- Counters are wrap-around, reset to 0 by rst_n, and also cleared synchronously by an added 1-bit input stat_clear. If stat_clear coincides with an increment, clear wins.
- When not defined: no ports or logic are added, and behaviour is otherwise identical.

Test Plan:
1. Fill: x=5, y=2, depth=all-ones, color=0x1234, compare=0, fb_wr_ready=1.
   -> fb write at addr 645 with color 0x1234; depth_wr at 645 with all-ones; no depth_rd_en; in_ready returns 1 two cycles after accept.
2. Pass: RAM[645]=1000, pixel at (5,2) with depth=500, compare=1.
   -> depth_rd_en at 645 one cycle after accept; fb write of the color; depth_wr_data=500.
3. Reject and equal: RAM[645]=500, send depth 500 and then depth 700.
   -> no fb_wr_valid or depth_wr_en for either; back to IDLE 3 cycles after each accept.
4. Clip: x=320, y=0 and x=0, y=240.
   -> no memory strobes; in_ready stays 1 continuously; with DEPTH_TEST_STATS_EN, stat_clipped=2.
5. Backpressure: hold fb_wr_ready=0 for 10 cycles during WRITE.
   -> fb_wr_valid, addr and color stable; in_ready=0; exactly one depth_wr_en pulse, on the cycle fb_wr_ready rises.
6. Reset mid-WRITE: drop rst_n while fb_wr_valid=1.
   -> all outputs 0 immediately (asynchronous); after release, in_ready=1 and the aborted pixel is never written.
